// File: rtl/life_engine.sv
// life_engine: streams one Game-of-Life generation from a source RAM to a
// destination RAM, visiting each cell in {y,x} order. Each cell costs 11
// cycles: nine reads (eight neighbours, then self), one capture cycle, and
// one write cycle.
// Optional feature: define LIFE_POPCOUNT_EN to count the live cells written
// in each generation. Without it, pop_count is tied to zero.
module life_engine #(
  parameter int         XW     = 6,
  parameter int         YW     = 6,
  parameter logic [8:0] RULE_B = 9'b000001000,
  parameter logic [8:0] RULE_S = 9'b000001100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             wrap_en,
  output logic             busy,
  output logic             done,
  output logic [XW+YW-1:0] addr_rd,
  output logic             we_rd,
  input  logic             din,
  output logic [XW+YW-1:0] addr_wr,
  output logic             we_wr,
  output logic             dout,
  output logic [15:0]      gen_count,
  output logic [XW+YW:0]   pop_count
);

  localparam int AW = XW + YW;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_LAST = 2'd2;
  localparam logic [1:0] S_WR   = 2'd3;
  localparam logic [XW-1:0] X_ONE   = XW'(1);
  localparam logic [YW-1:0] Y_ONE   = YW'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW-1:0] PTR_MAX = '1;

  logic [1:0]    r_state;
  logic [3:0]    r_k;
  logic [AW-1:0] r_ptr;
  logic [3:0]    r_n;
  logic          r_self;
  logic          r_wrap;
  logic          r_nbValid;
  logic          r_done;
  logic [15:0]   r_genCount;

  logic [XW-1:0] w_x;
  logic [YW-1:0] w_y;
  logic [XW-1:0] w_nx;
  logic [YW-1:0] w_ny;
  logic [1:0]    w_dx;
  logic [1:0]    w_dy;
  logic          w_offGrid;
  logic          w_ruleBit;

  assign w_x = r_ptr[XW-1:0];
  assign w_y = r_ptr[AW-1:XW];

  // Map read index k to a neighbour offset; 0 = minus one, 1 = same, 2 = plus one
  always_comb begin
    w_dx = 2'd1;
    w_dy = 2'd1;
    case (r_k)
      4'd0: begin w_dx = 2'd0; w_dy = 2'd0; end
      4'd1: w_dy = 2'd0;
      4'd2: begin w_dx = 2'd2; w_dy = 2'd0; end
      4'd3: w_dx = 2'd0;
      4'd4: w_dx = 2'd2;
      4'd5: begin w_dx = 2'd0; w_dy = 2'd2; end
      4'd6: w_dy = 2'd2;
      4'd7: begin w_dx = 2'd2; w_dy = 2'd2; end
      default: ;
    endcase
  end

  // Neighbour address always wraps; flag the ones that fell off an edge
  always_comb begin
    w_nx = w_x;
    w_ny = w_y;
    if (w_dx == 2'd0) w_nx = w_x - X_ONE;
    else if (w_dx == 2'd2) w_nx = w_x + X_ONE;
    if (w_dy == 2'd0) w_ny = w_y - Y_ONE;
    else if (w_dy == 2'd2) w_ny = w_y + Y_ONE;
    w_offGrid = (w_dx == 2'd0 && w_x == '0) || (w_dx == 2'd2 && w_x == '1) ||
                (w_dy == 2'd0 && w_y == '0) || (w_dy == 2'd2 && w_y == '1);
  end

  assign w_ruleBit = r_self ? RULE_S[r_n] : RULE_B[r_n];

  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign addr_rd   = (r_state == S_RD) ? {w_ny, w_nx} : '0;
  assign we_rd     = 1'b0;
  assign addr_wr   = r_ptr;
  assign we_wr     = (r_state == S_WR);
  assign dout      = (r_state == S_WR) ? w_ruleBit : 1'b0;
  assign gen_count = r_genCount;

  // Main sequencer: read neighbours, accumulate the count, write the result
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_k        <= '0;
      r_ptr      <= '0;
      r_n        <= '0;
      r_self     <= 1'b0;
      r_wrap     <= 1'b0;
      r_nbValid  <= 1'b0;
      r_done     <= 1'b0;
      r_genCount <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_ptr     <= '0;
            r_k       <= '0;
            r_n       <= '0;
            r_wrap    <= wrap_en;
            r_nbValid <= 1'b0;
            r_state   <= S_RD;
          end
        end
        S_RD: begin
          r_nbValid <= (r_k < 4'd8) && (r_wrap || !w_offGrid);
          if (r_k != 4'd0) r_n <= r_n + {3'b000, din & r_nbValid};
          if (r_k == 4'd8) r_state <= S_LAST;
          else r_k <= r_k + 4'd1;
        end
        S_LAST: begin
          r_self  <= din;
          r_state <= S_WR;
        end
        default: begin
          if (r_ptr == PTR_MAX) begin
            r_state    <= S_IDLE;
            r_done     <= 1'b1;
            r_genCount <= r_genCount + 16'd1;
          end else begin
            r_ptr   <= r_ptr + PTR_ONE;
            r_k     <= '0;
            r_n     <= '0;
            r_state <= S_RD;
          end
        end
      endcase
    end
  end

`ifdef LIFE_POPCOUNT_EN
  logic [AW:0] r_popAcc;
  logic [AW:0] r_popCount;

  // Count live writes; publish the total as the generation finishes
  always_ff @(posedge clk) begin
    if (rst) begin
      r_popAcc   <= '0;
      r_popCount <= '0;
    end else if (r_state == S_IDLE && start) begin
      r_popAcc <= '0;
    end else if (r_state == S_WR) begin
      r_popAcc <= r_popAcc + {{AW{1'b0}}, w_ruleBit};
      if (r_ptr == PTR_MAX) r_popCount <= r_popAcc + {{AW{1'b0}}, w_ruleBit};
    end
  end

  assign pop_count = r_popCount;
`else
  assign pop_count = '0;
`endif

endmodule

// File: tb/tb_life_engine.sv
// tb_life_engine: directed bench for life_engine on 8x8 grids. Instance A
// uses the default rules; instance B uses a born-on-one, never-survive rule.
module tb_life_engine;

`ifdef LIFE_POPCOUNT_EN
  localparam int POP_ON = 1;
`else
  localparam int POP_ON = 0;
`endif

  logic clk;
  logic rst;
  logic startA, wrapA, busyA, doneA, weRdA, dinA, weA, doutA;
  logic [5:0] addrRdA, addrWrA;
  logic [15:0] genA;
  logic [6:0] popA;
  logic startB, wrapB, busyB, doneB, weRdB, dinB, weB, doutB;
  logic [5:0] addrRdB, addrWrB;
  logic [15:0] genB;
  logic [6:0] popB;

  logic [63:0] srcMem;
  logic [63:0] dstA, dstB;
  int writesA, onesA, donesA, writesB, onesB, donesB;

  int vectors;
  int miscompares;

  life_engine #(.XW(3), .YW(3)) u_dutA (
    .clk(clk), .rst(rst), .start(startA), .wrap_en(wrapA),
    .busy(busyA), .done(doneA), .addr_rd(addrRdA), .we_rd(weRdA),
    .din(dinA), .addr_wr(addrWrA), .we_wr(weA), .dout(doutA),
    .gen_count(genA), .pop_count(popA)
  );

  life_engine #(.XW(3), .YW(3), .RULE_B(9'b000000010), .RULE_S(9'b000000000)) u_dutB (
    .clk(clk), .rst(rst), .start(startB), .wrap_en(wrapB),
    .busy(busyB), .done(doneB), .addr_rd(addrRdB), .we_rd(weRdB),
    .din(dinB), .addr_wr(addrWrB), .we_wr(weB), .dout(doutB),
    .gen_count(genB), .pop_count(popB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Source RAM with one cycle of read latency, shared by both instances
  always @(posedge clk) begin
    dinA <= srcMem[addrRdA];
    dinB <= srcMem[addrRdB];
  end

  // Destination RAMs plus write and done tallies
  always @(posedge clk) begin
    if (weA) begin
      dstA[addrWrA] <= doutA;
      writesA <= writesA + 1;
      if (doutA) onesA <= onesA + 1;
    end
    if (doneA) donesA <= donesA + 1;
    if (weB) begin
      dstB[addrWrB] <= doutB;
      writesB <= writesB + 1;
      if (doutB) onesB <= onesB + 1;
    end
    if (doneB) donesB <= donesB + 1;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [63:0] setCell(input logic [63:0] v, input int x, input int y);
    logic [63:0] r;
    r = v;
    r[y*8+x] = 1'b1;
    return r;
  endfunction

  // Run one generation on A or B; optionally poke start while busy
  task automatic applyStimulus(input bit selB, input bit wrapIn, input bit pokeBusy,
                               output int cycles);
    bit found;
    @(negedge clk);
    if (selB) begin wrapB = wrapIn; startB = 1'b1; end
    else begin wrapA = wrapIn; startA = 1'b1; end
    @(posedge clk);
    cycles = 1;
    found = 1'b0;
    @(negedge clk);
    startA = 1'b0;
    startB = 1'b0;
    while (!found && cycles < 2000) begin
      @(posedge clk);
      cycles++;
      @(negedge clk);
      if (pokeBusy && !selB) startA = (cycles == 100);
      if (selB ? doneB : doneA) found = 1'b1;
    end
    startA = 1'b0;
  endtask

  initial begin
    logic [63:0] expA;
    int cycles;
    int baseWrites, baseOnes, baseDones;
    bit hit;

    vectors = 0;
    miscompares = 0;
    writesA = 0; onesA = 0; donesA = 0;
    writesB = 0; onesB = 0; donesB = 0;
    srcMem = '0;
    startA = 1'b1;
    startB = 1'b0;
    wrapA = 1'b1;
    wrapB = 1'b1;
    rst = 1'b1;

    // Reset holds the engine idle even with start asserted
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst busy", {63'd0, busyA}, 64'd0);
    checkOutput("rst done", {63'd0, doneA}, 64'd0);
    checkOutput("rst we_wr", {63'd0, weA}, 64'd0);
    checkOutput("rst dout", {63'd0, doutA}, 64'd0);
    checkOutput("rst gen_count", {48'd0, genA}, 64'd0);
    checkOutput("rst pop_count", {57'd0, popA}, 64'd0);
    checkOutput("rst addr_rd", {58'd0, addrRdA}, 64'd0);
    checkOutput("rst addr_wr", {58'd0, addrWrA}, 64'd0);
    startA = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("idle busy", {63'd0, busyA}, 64'd0);

    // Horizontal blinker flips to vertical; stray start while busy is ignored
    srcMem = setCell(setCell(setCell(64'd0, 3, 4), 4, 4), 5, 4);
    expA = setCell(setCell(setCell(64'd0, 4, 3), 4, 4), 4, 5);
    baseWrites = writesA; baseOnes = onesA; baseDones = donesA;
    applyStimulus(1'b0, 1'b1, 1'b1, cycles);
    checkOutput("blinker latency", 64'(cycles), 64'd705);
    checkOutput("blinker busy at done", {63'd0, busyA}, 64'd0);
    checkOutput("blinker gen_count", {48'd0, genA}, 64'd1);
    checkOutput("blinker pop_count", {57'd0, popA}, (POP_ON != 0) ? 64'd3 : 64'd0);
    repeat (30) @(negedge clk);
    checkOutput("blinker grid", dstA, expA);
    checkOutput("blinker writes", 64'(writesA - baseWrites), 64'd64);
    checkOutput("blinker ones", 64'(onesA - baseOnes), 64'd3);
    checkOutput("blinker done pulses", 64'(donesA - baseDones), 64'd1);
    checkOutput("blinker gen after poke", {48'd0, genA}, 64'd1);
    checkOutput("idle addr_rd", {58'd0, addrRdA}, 64'd0);

    // Corner block persists on a torus
    srcMem = setCell(setCell(setCell(setCell(64'd0, 0, 0), 7, 0), 0, 7), 7, 7);
    applyStimulus(1'b0, 1'b1, 1'b0, cycles);
    checkOutput("wrap latency", 64'(cycles), 64'd705);
    checkOutput("wrap gen_count", {48'd0, genA}, 64'd2);
    checkOutput("wrap pop_count", {57'd0, popA}, (POP_ON != 0) ? 64'd4 : 64'd0);
    @(negedge clk);
    checkOutput("wrap grid", dstA, srcMem);

    // Same block with dead edges dies out
    baseOnes = onesA;
    applyStimulus(1'b0, 1'b0, 1'b0, cycles);
    checkOutput("dead gen_count", {48'd0, genA}, 64'd3);
    checkOutput("dead pop_count", {57'd0, popA}, 64'd0);
    @(negedge clk);
    checkOutput("dead grid", dstA, 64'd0);
    checkOutput("dead ones", 64'(onesA - baseOnes), 64'd0);

    // Born-on-one seed grows into its eight neighbours
    srcMem = setCell(64'd0, 2, 2);
    expA = 64'd0;
    for (int dy = -1; dy <= 1; dy++)
      for (int dx = -1; dx <= 1; dx++)
        if (dx != 0 || dy != 0) expA = setCell(expA, 2 + dx, 2 + dy);
    applyStimulus(1'b1, 1'b1, 1'b0, cycles);
    checkOutput("seed latency", 64'(cycles), 64'd705);
    checkOutput("seed gen_count", {48'd0, genB}, 64'd1);
    checkOutput("seed pop_count", {57'd0, popB}, (POP_ON != 0) ? 64'd8 : 64'd0);
    @(negedge clk);
    checkOutput("seed grid", dstB, expA);
    checkOutput("seed ones", 64'(onesB), 64'd8);
    checkOutput("seed done pulses", 64'(donesB), 64'd1);

    // Reset in the middle of a generation aborts it cleanly
    srcMem = setCell(64'd0, 1, 1);
    @(negedge clk);
    wrapA = 1'b1;
    startA = 1'b1;
    @(negedge clk);
    startA = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 500 && !hit; i++) begin
      if (addrWrA == 6'd10) hit = 1'b1;
      else @(negedge clk);
    end
    checkOutput("abort reached cell 10", {63'd0, hit}, 64'd1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort busy", {63'd0, busyA}, 64'd0);
    checkOutput("abort we_wr", {63'd0, weA}, 64'd0);
    checkOutput("abort gen_count", {48'd0, genA}, 64'd0);
    checkOutput("abort done", {63'd0, doneA}, 64'd0);
    rst = 1'b0;
    baseWrites = writesA; baseDones = donesA;
    repeat (60) @(negedge clk);
    checkOutput("abort later writes", 64'(writesA - baseWrites), 64'd0);
    checkOutput("abort later dones", 64'(donesA - baseDones), 64'd0);
    checkOutput("abort stays idle", {63'd0, busyA}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
